// File: rtl/button_bounce_if.sv
// Button interface between a mechanical-button emulator and its consumer.
//
// Signals:
//   clean_in      requested button level, synchronous to the clock
//   button_out    emulated bouncy button level
//   busy          high while a bounce/settle sequence is in progress
//   done          one-cycle pulse when a sequence completes
//   last_bounces  bounce count N (1..4) of the most recent sequence
//
// Modports:
//   master  the emulator: takes clean_in, drives everything else
//   slave   the requester/consumer: drives clean_in, observes the rest
interface button_bounce_if;
  logic       clean_in;
  logic       button_out;
  logic       busy;
  logic       done;
  logic [2:0] last_bounces;

  modport master (
    input  clean_in,
    output button_out,
    output busy,
    output done,
    output last_bounces
  );

  modport slave (
    output clean_in,
    input  button_out,
    input  busy,
    input  done,
    input  last_bounces
  );
endinterface

// File: rtl/button_bounce_gen.sv
// Mechanical-button emulator. A clean level request on clean_in is turned
// into a contact-bounce burst followed by a settled level on button_out.
// Bounce count and glitch widths come from a 16-bit Galois LFSR so that
// debounce/toggle logic can be exercised on-chip and in simulation.
//
// Ports:
//   clk  clock, all logic on the rising edge
//   rst  synchronous active-high reset; aborts any running sequence
//   bb   button interface (master side): clean_in in; button_out, busy,
//        done, last_bounces out
//
// Parameters:
//   SEED            LFSR reset value (0 is replaced by 16'hACE1)
//   MAX_GLITCH_CYC  longest bounce segment in cycles, 1..4
//   SETTLE_CYC      cycles button_out is held after the last bounce, >= 1
//   BOUNCE_EN       0 forces a single clean edge per request
module button_bounce_gen #(
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          MAX_GLITCH_CYC = 4,
  parameter int          SETTLE_CYC     = 8,
  parameter bit          BOUNCE_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  button_bounce_if.master bb
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam int          SW       = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, GLITCH, SETTLE} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic          level_q;
  logic          target;
  logic          button_out;
  logic          busy;
  logic          done;
  logic [2:0]    last_bounces;
  logic [2:0]    seg_cnt;
  logic [2:0]    toggles_left;
  logic [SW-1:0] settle_cnt;

  logic [15:0]   lfsr_next;
  logic [2:0]    n_draw;
  logic [2:0]    l_draw;
  logic          settle_last;
  logic          start;

  // Bounce count lookup: mostly single edges, occasionally 2..4 bounces.
  function automatic logic [2:0] bounce_count(input logic [2:0] idx);
    logic [2:0] n;
    n = 3'd1;
    if (BOUNCE_EN) begin
      case (idx)
        3'd5:    n = 3'd2;
        3'd6:    n = 3'd3;
        3'd7:    n = 3'd4;
        default: n = 3'd1;
      endcase
    end
    return n;
  endfunction

  // Segment length 1..MAX_GLITCH_CYC from two LFSR bits.
  function automatic logic [2:0] seg_len(input logic [1:0] sel);
    int m;
    m = int'(sel) % MAX_GLITCH_CYC;
    return 3'(m + 1);
  endfunction

  // All random draws use the LFSR value before this cycle's shift.
  always_comb begin
    lfsr_next   = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0);
    n_draw      = bounce_count(lfsr[2:0]);
    l_draw      = seg_len(lfsr[5:4]);
    settle_last = (state == SETTLE) && (settle_cnt == SW'(1));
    // A request pending at the end of SETTLE starts straight away, in the
    // same cycle as the done pulse, so back-to-back requests lose no cycle.
    start       = ((state == IDLE) && (bb.clean_in != level_q)) ||
                  (settle_last && (bb.clean_in != target));
  end

  // Working counters and target carry no reset: they are always loaded
  // when a sequence starts, before they are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      level_q      <= 1'b0;
      button_out   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      last_bounces <= 3'd0;
      lfsr         <= SEED_EFF;
    end else begin
      lfsr <= lfsr_next;
      done <= 1'b0;

      case (state)
        IDLE: begin
        end
        GLITCH: begin
          if (seg_cnt == 3'd1) begin
            button_out   <= ~button_out;
            toggles_left <= toggles_left - 3'd1;
            seg_cnt      <= l_draw;
            // Toggle count is even, so the last toggle lands on target.
            if (toggles_left == 3'd1) begin
              state      <= SETTLE;
              settle_cnt <= SW'(SETTLE_CYC);
            end
          end else begin
            seg_cnt <= seg_cnt - 3'd1;
          end
        end
        SETTLE: begin
          if (settle_last) begin
            level_q <= target;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // New sequence: first edge goes straight to the requested level.
      if (start) begin
        target       <= bb.clean_in;
        button_out   <= bb.clean_in;
        last_bounces <= n_draw;
        busy         <= 1'b1;
        if (n_draw == 3'd1) begin
          state      <= SETTLE;
          settle_cnt <= SW'(SETTLE_CYC);
        end else begin
          state        <= GLITCH;
          toggles_left <= (n_draw - 3'd1) << 1;
          seg_cnt      <= l_draw;
        end
      end
    end
  end

  assign bb.button_out   = button_out;
  assign bb.busy         = busy;
  assign bb.done         = done;
  assign bb.last_bounces = last_bounces;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Testbench for button_bounce_gen. Two instances: dut_a with bouncing
// disabled (exact timing checks), dut_b with bouncing enabled and a seed
// whose low bits force N=4 on the first request after reset. A monitor
// per instance tracks transitions and segment widths and, on every done
// pulse, pops the expected final level from that instance's scoreboard.
module tb_button_bounce_gen;

  localparam int SETTLE = 8;
  localparam int MAXG   = 4;

  logic clk = 1'b0;
  logic a_rst;
  logic b_rst;

  button_bounce_if a_if();
  button_bounce_if b_if();

  button_bounce_gen #(
    .SEED(16'hACE1), .MAX_GLITCH_CYC(MAXG), .SETTLE_CYC(SETTLE), .BOUNCE_EN(1'b0)
  ) dut_a (
    .clk(clk), .rst(a_rst), .bb(a_if)
  );

  button_bounce_gen #(
    .SEED(16'hACE7), .MAX_GLITCH_CYC(MAXG), .SETTLE_CYC(SETTLE), .BOUNCE_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst(b_rst), .bb(b_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic qa[$];
  logic qb[$];

  logic m_prev_out[2];
  logic m_prev_busy[2];
  logic m_in_seq[2];
  int   m_trans[2];
  int   m_run[2];
  int   m_lb[2];

  logic trace_ref[64];
  int   tlen_ref;
  logic trace_cur[64];
  int   tlen_cur;
  int   tv[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pop_exp(input int id);
    int v;
    v = -1;
    if (id == 0) begin
      if (qa.size() != 0) v = int'(qa.pop_front());
    end else begin
      if (qb.size() != 0) v = int'(qb.pop_front());
    end
    return v;
  endfunction

  task automatic mon_step(input int id, input logic r, input logic out,
                          input logic bsy, input logic dn, input logic [2:0] lb);
    if (r) begin
      m_prev_out[id]  = 1'b0;
      m_prev_busy[id] = 1'b0;
      m_in_seq[id]    = 1'b0;
      m_trans[id]     = 0;
      m_run[id]       = 0;
    end else begin
      if (dn) begin
        if (!m_in_seq[id]) begin
          check($sformatf("done_without_sequence[%0d]", id), 1, 0);
        end else begin
          check($sformatf("final_level[%0d]", id), int'(m_prev_out[id]), pop_exp(id));
          check($sformatf("transitions[%0d]", id), m_trans[id], 2 * m_lb[id] - 1);
          check($sformatf("settle_cycles[%0d]", id), m_run[id], SETTLE);
        end
        m_in_seq[id] = 1'b0;
      end else if (m_in_seq[id]) begin
        if (out != m_prev_out[id]) begin
          n_tests++;
          if (m_run[id] < 1 || m_run[id] > MAXG) begin
            n_fail++;
            $display("FAIL segment_len[%0d]: got %0d cycles, expected 1..%0d", id, m_run[id], MAXG);
          end
          m_trans[id]++;
          m_run[id] = 1;
        end else begin
          m_run[id]++;
        end
      end
      if (bsy && (!m_prev_busy[id] || dn)) begin
        m_in_seq[id] = 1'b1;
        m_trans[id]  = (out != m_prev_out[id]) ? 1 : 0;
        m_run[id]    = 1;
        m_lb[id]     = int'(lb);
        n_tests++;
        if (lb < 3'd1 || lb > 3'd4) begin
          n_fail++;
          $display("FAIL last_bounces_range[%0d]: got %0d, expected 1..4", id, lb);
        end
      end
      m_prev_out[id]  = out;
      m_prev_busy[id] = bsy;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, a_rst, a_if.button_out, a_if.busy, a_if.done, a_if.last_bounces);
    mon_step(1, b_rst, b_if.button_out, b_if.busy, b_if.done, b_if.last_bounces);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int id);
    return (id == 0) ? a_if.busy : b_if.busy;
  endfunction

  task automatic wait_idle(input int id, input int budget);
    int k;
    k = 0;
    tick();
    while (busy_of(id) && k < budget) begin
      tick();
      k++;
    end
    if (busy_of(id)) check($sformatf("idle_timeout[%0d]", id), 1, 0);
  endtask

  task automatic check_outs(input int id, input string tag, input int eo, input int eb, input int ed);
    if (id == 0) begin
      check({tag, "_out"},  int'(a_if.button_out), eo);
      check({tag, "_busy"}, int'(a_if.busy), eb);
      check({tag, "_done"}, int'(a_if.done), ed);
    end else begin
      check({tag, "_out"},  int'(b_if.button_out), eo);
      check({tag, "_busy"}, int'(b_if.busy), eb);
      check({tag, "_done"}, int'(b_if.done), ed);
    end
  endtask

  // Records dut_b's button_out from the current sample through the done sample.
  task automatic record_b();
    tlen_cur = 0;
    trace_cur[0] = b_if.button_out;
    tlen_cur = 1;
    while (!b_if.done && tlen_cur < 64) begin
      tick();
      trace_cur[tlen_cur] = b_if.button_out;
      tlen_cur++;
    end
    if (!b_if.done) check("record_b_timeout", 1, 0);
  endtask

  initial begin
    int ntr;
    int p;
    int diff;
    logic prev;

    a_rst = 1'b1;
    b_rst = 1'b1;
    a_if.clean_in = 1'b1;
    b_if.clean_in = 1'b1;

    // Reset held three cycles with clean_in high: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs(0, $sformatf("reset_a%0d", i), 0, 0, 0);
      check(     $sformatf("reset_a%0d_lb", i), int'(a_if.last_bounces), 0);
      check_outs(1, $sformatf("reset_b%0d", i), 0, 0, 0);
      check(     $sformatf("reset_b%0d_lb", i), int'(b_if.last_bounces), 0);
    end

    // Release: both start a sequence on the very next edge.
    a_rst = 1'b0;
    b_rst = 1'b0;
    qa.push_back(1'b1);
    qb.push_back(1'b1);
    tick();
    check_outs(0, "post_reset_a", 1, 1, 0);
    check("post_reset_a_lb", int'(a_if.last_bounces), 1);
    check_outs(1, "post_reset_b", 1, 1, 0);
    check("forced_n4_lb", int'(b_if.last_bounces), 4);

    // Forced N=4: seed 16'hACE7 gives segments 3 then 2 first.
    record_b();
    check("n4_seg1_end", int'(trace_cur[2]), 1);
    check("n4_seg2_start", int'(trace_cur[3]), 0);
    check("n4_seg2_end", int'(trace_cur[4]), 0);
    check("n4_seg3_start", int'(trace_cur[5]), 1);
    for (int k = 0; k < 8; k++) tv[k] = -1;
    ntr = 0;
    p = 0;
    prev = 1'b0;
    for (int j = 0; j < tlen_cur - 1; j++) begin
      if (trace_cur[j] != prev) begin
        if (ntr < 8) tv[ntr] = int'(trace_cur[j]);
        ntr++;
        p = j;
      end
      prev = trace_cur[j];
    end
    check("n4_transitions", ntr, 7);
    for (int k = 0; k < 7; k++) check($sformatf("n4_edge%0d_level", k), tv[k], (k % 2 == 0) ? 1 : 0);
    check("n4_stable_before_done", tlen_cur - 1 - p, SETTLE);
    tlen_ref = tlen_cur;
    for (int j = 0; j < 64; j++) trace_ref[j] = trace_cur[j];

    // dut_a back to 0, then the exact-timing clean edge 0 -> 1.
    a_if.clean_in = 1'b0;
    qa.push_back(1'b0);
    wait_idle(0, 40);
    a_if.clean_in = 1'b1;
    qa.push_back(1'b1);
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 1) check("clean_edge_lb", int'(a_if.last_bounces), 1);
      if (j <= 8)       check_outs(0, $sformatf("clean_edge_c%0d", j), 1, 1, 0);
      else if (j == 9)  check_outs(0, "clean_edge_done", 1, 0, 1);
      else              check_outs(0, "clean_edge_after", 1, 0, 0);
    end

    // Back to 0, then 0 -> 1 with a return to 0 while busy.
    a_if.clean_in = 1'b0;
    qa.push_back(1'b0);
    wait_idle(0, 40);
    a_if.clean_in = 1'b1;
    qa.push_back(1'b1);
    tick();
    tick();
    a_if.clean_in = 1'b0;
    qa.push_back(1'b0);
    for (int j = 3; j <= 18; j++) begin
      tick();
      if (j <= 8)       check_outs(0, $sformatf("retrig_c%0d", j), 1, 1, 0);
      else if (j == 9)  check_outs(0, "retrig_done_restart", 0, 1, 1);
      else if (j <= 16) check_outs(0, $sformatf("retrig_c%0d", j), 0, 1, 0);
      else if (j == 17) check_outs(0, "retrig_done2", 0, 0, 1);
      else              check_outs(0, "retrig_after", 0, 0, 0);
    end

    // Reset mid-GLITCH on dut_b, then an identical replay from SEED.
    b_rst = 1'b1;
    tick();
    tick();
    check_outs(1, "replay_reset", 0, 0, 0);
    b_rst = 1'b0;
    qb.push_back(1'b1);
    diff = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (b_if.button_out != trace_ref[j]) diff++;
    end
    check("partial_replay_diffs", diff, 0);
    qb.delete();
    b_rst = 1'b1;
    tick();
    check_outs(1, "abort", 0, 0, 0);
    tick();
    check_outs(1, "abort_hold", 0, 0, 0);
    b_rst = 1'b0;
    qb.push_back(1'b1);
    tick();
    record_b();
    check("replay_length", tlen_cur, tlen_ref);
    diff = 0;
    for (int j = 0; j < 64; j++) if (j < tlen_ref && trace_cur[j] != trace_ref[j]) diff++;
    check("replay_diffs", diff, 0);

    // 100 requests with bouncing; every fourth carries a pulse while busy.
    for (int i = 0; i < 100; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      b_if.clean_in = ~b_if.clean_in;
      qb.push_back(b_if.clean_in);
      if (i % 4 == 0) begin
        tick();
        tick();
        b_if.clean_in = ~b_if.clean_in;
        tick();
        b_if.clean_in = ~b_if.clean_in;
      end
      wait_idle(1, 80);
    end

    for (int j = 0; j < 4; j++) tick();
    check("scoreboard_a_left", qa.size(), 0);
    check("scoreboard_b_left", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/button_bounce_gen.md
Name: button_bounce_gen

Overview:
- Synthesizable mechanical-button emulator: the driving end of the button interface consumed by `buttonFsm`.
- Takes a clean, clock-synchronous level request and produces `button_out`: a contact-bounce burst, then a settled level.
- Bounce count and glitch widths are pseudo-random from an internal LFSR, so debounce/toggle FSMs can be exercised on-chip and in simulation.

Parameters:
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.
- MAX_GLITCH_CYC, 4: maximum width of one bounce segment, in cycles. Range 1..4.
- SETTLE_CYC, 8: cycles `button_out` is held stable after the last bounce. Must be ≥1.
- BOUNCE_EN, 1: when 0, the bounce count is forced to 1 (clean edges only).

Ports:
- clk, input, 1: clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- clean_in, input, 1: requested button level; synchronous to clk.
- button_out, output, 1: emulated bouncy button level.
- busy, output, 1: high while a bounce/settle sequence is in progress.
- done, output, 1: one-cycle pulse when a sequence completes.
- last_bounces, output, 3: bounce count N of the most recent sequence (1..4).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, level_q=0, button_out=0, busy=0, done=0, last_bounces=0, lfsr=SEED (0→16'hACE1). Reset mid-sequence aborts it immediately; no done pulse.
- LFSR:
  - 16-bit Galois, taps 16'hB400, shifts right every non-reset cycle.
  - Reads below use the value before that cycle's shift.
- Bounce count N = table[lfsr[2:0]]:
  - Index 0..7 maps to 1,1,1,1,1,2,3,4.
  - Forced to 1 when BOUNCE_EN=0.
- Segment length L = 1 + (lfsr[5:4] mod MAX_GLITCH_CYC). L is redrawn each time a segment is loaded.
- IDLE:
  - button_out=level_q, busy=0.
  - When clean_in≠level_q at a posedge: target←clean_in, button_out←target, last_bounces←N, busy←1.
  - If N=1: go to SETTLE with settle_cnt←SETTLE_CYC.
  - Else: go to GLITCH with toggles_left←2(N−1) and seg_cnt←L.
- Latency: first `button_out` edge is visible the cycle after clean_in changes (1 cycle).
- GLITCH:
  - seg_cnt decrements each cycle.
  - On the cycle seg_cnt=1: button_out toggles, toggles_left decrements, and seg_cnt←new L.
  - When toggles_left reaches 0, button_out equals target; go to SETTLE with settle_cnt←SETTLE_CYC.
  - Result: exactly 2N−1 transitions total, always ending on target.
- SETTLE:
  - button_out is held at target; settle_cnt decrements.
  - On the cycle settle_cnt=1: level_q←target, busy←0, done←1 for one cycle; state→IDLE.
- clean_in changes while busy: ignored, not queued. IDLE compares again on its first cycle.
  - If clean_in≠level_q, a new sequence starts in that same cycle, so done and the new busy=1 are both asserted.
- A clean_in pulse that returns to level_q while busy produces no further sequence.
- busy duration for one sequence = sum of all segment lengths + SETTLE_CYC cycles.
- done is never asserted while rst=1.

Test Plan:
1. Reset: hold rst 3 cycles with clean_in=1 → button_out=0, busy=0, done=0, last_bounces=0 throughout. After release, a sequence starts the next posedge.
2. BOUNCE_EN=0, SETTLE_CYC=8: clean_in 0→1 sampled at cycle 10 →
   - button_out=1 from cycle 11 with no further transitions;
   - busy high cycles 11–18;
   - done=1 only at cycle 19;
   - last_bounces=1.
3. BOUNCE_EN=1, loop 100 random requests: each sequence must show
   - exactly 2·last_bounces−1 button_out transitions before done;
   - every segment 1..MAX_GLITCH_CYC cycles;
   - final level = clean_in at request time;
   - scoreboard checks all three.
4. Forced N=4 (SEED chosen so lfsr[2:0]=7 at the request) → 7 transitions 1,0,1,0,1,0,1, then 8 stable cycles, then done.
5. clean_in 0→1, then back to 0 at cycle +2 while busy → first sequence completes to 1. In the done cycle, a new 1→0 sequence starts with busy=1.
6. rst asserted mid-GLITCH → next cycle button_out=0, busy=0, and no done pulse. LFSR restarts at SEED, giving an identical replay of the same stimulus.
